// File: rtl/wb_uart_rx_fifo.sv
// 8N1 UART receiver feeding a DEPTH-entry byte FIFO, drained through a
// Wishbone B4 pipelined slave: reads pop one byte with status, writes flush/clear.
module wb_uart_rx_fifo #(
  parameter int TICKS_PER_BAUD = 8,
  parameter int DEPTH          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic        uart_rx
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TICKS_PER_BAUD);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BAUD - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta, rxs;
  state_t        state_reg, state_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          push, frame_err;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_reg;
  logic          ovr_reg, ferr_reg;

  logic req, rd, wr, pop, flush, clr, full, push_ok, ovr_set;
  logic [7:0] count8;

  wire unused_dat = ^wb_dat_i[31:2];

  assign wb_stall_o = 1'b0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      rx_meta   <= uart_rx;
      rxs       <= rx_meta;
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        tick_next = '0;
        // Start on the cycle rxs itself goes 1 -> 0 (its next value is rx_meta).
        if (rxs && !rx_meta) state_next = START;
      end
      START: begin
        if (tick_reg == TICK_HALF) begin
          tick_next  = '0;
          bit_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_reg == TICK_LAST) begin
          tick_next  = '0;
          shift_next = {rxs, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (tick_reg == TICK_LAST) begin
          tick_next  = '0;
          push       = rxs;
          frame_err  = !rxs;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req     = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign rd      = req && !wb_we_i;
  assign wr      = req && wb_we_i;
  assign full    = (count_reg == FULL_CNT);
  assign pop     = rd && (count_reg != '0);
  assign flush   = wr && wb_dat_i[0];
  assign clr     = wr && wb_dat_i[1];
  assign push_ok = push && !full && !flush;
  assign ovr_set = push && full;
  assign count8  = 8'(count_reg);

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
      ovr_reg   <= 1'b0;
      ferr_reg  <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
    end else begin
      wb_ack_o <= req;
      if (rd)
        wb_dat_o <= {8'h00, count8, 5'h00, ferr_reg, ovr_reg, pop,
                     pop ? mem[rd_ptr] : 8'h00};
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count_reg <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
      // A flag event in the same cycle as a clear keeps the flag set.
      ovr_reg  <= ovr_set   || (ovr_reg  && !clr);
      ferr_reg <= frame_err || (ferr_reg && !clr);
    end
  end

endmodule

// File: tb/tb_wb_uart_rx_fifo.sv
// Directed + randomized bench for wb_uart_rx_fifo against a queue-based
// model of the FIFO contents and sticky flags.
module tb_wb_uart_rx_fifo;

  localparam int T     = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack, stall;
  logic        rx;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  q[$];
  logic        m_ovr, m_ferr;
  logic [31:0] last_word;

  wb_uart_rx_fifo #(.TICKS_PER_BAUD(T), .DEPTH(DEPTH)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_dat_i  (dat_i),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_stall_o(stall),
    .uart_rx   (rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr     = 1'b0;
    m_ferr    = 1'b0;
    last_word = 32'h0;
  endtask

  // A completed frame: bad stop bit -> ferr; full FIFO -> ovr; else enqueue.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop)                m_ferr = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else                      q.push_back(b);
  endtask

  // Line is left high afterwards; the frame has been pushed (or rejected) on return.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    repeat (T) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (T) @(posedge clk);
    end
    #1 rx = stop;
    repeat (T) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    model_frame(b, stop);
    $display("frame  byte=%h stop=%0d fifo_level=%0d", b, stop, q.size());
  endtask

  task automatic bus_read(input string tag);
    logic        valid;
    logic [7:0]  head;
    logic [31:0] exp;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    valid = (q.size() != 0);
    head  = valid ? q[0] : 8'h00;
    exp   = {8'h00, 8'(q.size()), 5'h00, m_ferr, m_ovr, valid, head};
    check({tag, "_ack"}, {31'h0, ack}, 32'h1);
    check(tag, dat_o, exp);
    $display("read   %s data=%h expect=%h", tag, dat_o, exp);
    if (valid) void'(q.pop_front());
    last_word = exp;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ackpulse"}, {31'h0, ack}, 32'h0);
  endtask

  task automatic bus_write(input string tag, input logic [31:0] d);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; dat_i = d;
    @(posedge clk); #1;
    check({tag, "_ack"}, {31'h0, ack}, 32'h1);
    check({tag, "_dat"}, dat_o, last_word);
    $display("write  %s data=%h", tag, d);
    if (d[0]) q.delete();
    if (d[1]) begin m_ovr = 1'b0; m_ferr = 1'b0; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = 32'h0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    rst_n = 1'b1;

    // Reset in the middle of a frame abandons it.
    @(posedge clk); #1 rx = 1'b0;
    repeat (40) @(posedge clk); #1;
    rst_n = 1'b0; rx = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("midrst_dat", dat_o, 32'h0);
    rst_n = 1'b1;
    model_reset();
    repeat (100) @(posedge clk);
    bus_read("after_reset");

    // Single byte, then an empty read.
    send_frame(8'hA5, 1'b1);
    bus_read("single");
    check("single_const", last_word, 32'h0001_01A5);
    bus_read("single_empty");

    // 17-byte burst overflows a 16-entry FIFO.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    for (int i = 0; i < 16; i++) bus_read($sformatf("burst%0d", i));
    bus_write("clr_ovr", 32'h2);
    bus_read("burst_empty");

    // Framing error, then a good frame with ferr still sticky.
    send_frame(8'h3C, 1'b0);
    bus_read("ferr_empty");
    check("ferr_const", last_word, 32'h0000_0400);
    send_frame(8'h55, 1'b1);
    bus_read("after_ferr");
    check("after_ferr_const", last_word, 32'h0001_0555);
    bus_write("clr_ferr", 32'h2);

    // 3-cycle start glitch must not start a frame.
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk); #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    bus_read("glitch_empty");
    send_frame(8'h81, 1'b1);
    bus_read("after_glitch");
    check("after_glitch_const", last_word, 32'h0001_0181);

    // Pop at count 1 landing on the push edge (78 edges after the start bit).
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (76) @(posedge clk);
        bus_read("coinc_pop");
      end
    join
    bus_read("coinc_next");

    // Flush with 5 bytes queued.
    for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    bus_write("flush", 32'h1);
    bus_read("flush_empty");

    // Randomized mix of frames, reads and control writes.
    for (int n = 0; n < 30; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5)
        send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0);
      else if (op < 9)
        bus_read($sformatf("rnd%0d", n));
      else
        bus_write($sformatf("rndw%0d", n), 32'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    while (q.size() != 0) bus_read("drain");
    bus_read("drain_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
